// File: rtl/change_dispenser.sv
// Change dispenser: releases one bottle per vend request and pays out Rs5
// coins from the hopper, with a one-deep request queue, sensor timeouts and
// a sticky fault state.
module change_dispenser #(
    parameter int unsigned PULSE_W = 4,
    parameter int unsigned TIMEOUT = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vend,
    input  logic [1:0] change,
    input  logic       item_done,
    input  logic       coin_done,
    output logic       item_motor,
    output logic       coin_eject,
    output logic       busy,
    output logic       overflow,
    output logic       fault
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        ITEM       = 3'd1,
        COIN_PULSE = 3'd2,
        COIN_WAIT  = 3'd3,
        FAULT      = 3'd4
    } state_t;

    state_t      state, nxt_state;
    logic [1:0]  coins, nxt_coins;
    logic [7:0]  pcnt, nxt_pcnt;
    logic [15:0] tcnt, nxt_tcnt;
    logic        pvld, nxt_pvld;
    logic        pvend, nxt_pvend;
    logic [1:0]  pcoins, nxt_pcoins;
    logic        nxt_ovf;

    logic [1:0]  req_coins;
    logic        req;
    logic        take_new;
    logic        launch;
    logic        l_vend;
    logic [1:0]  l_coins;

    // Decode the incoming request; change=11 contributes no coins
    always_comb begin
        req_coins = 2'd0;
        if (change == 2'b01) req_coins = 2'd1;
        if (change == 2'b10) req_coins = 2'd2;
        req = vend | (req_coins != 2'd0);
    end

    // Next-state, counter and queue logic
    always_comb begin
        nxt_state  = state;
        nxt_coins  = coins;
        nxt_pcnt   = pcnt;
        nxt_tcnt   = tcnt;
        nxt_pvld   = pvld;
        nxt_pvend  = pvend;
        nxt_pcoins = pcoins;
        nxt_ovf    = overflow;
        take_new   = 1'b0;
        launch     = 1'b0;
        l_vend     = vend;
        l_coins    = req_coins;

        case (state)
            IDLE: begin
                // A queued request always goes ahead of a fresh one
                if (pvld) begin
                    launch   = 1'b1;
                    l_vend   = pvend;
                    l_coins  = pcoins;
                    nxt_pvld = 1'b0;
                end else if (req) begin
                    launch   = 1'b1;
                    take_new = 1'b1;
                end
            end
            ITEM: begin
                if (item_done) begin
                    if (coins != 2'd0) begin
                        nxt_state = COIN_PULSE;
                        nxt_pcnt  = 8'd0;
                    end else begin
                        nxt_state = IDLE;
                    end
                end else if (tcnt == 16'(TIMEOUT - 1)) begin
                    nxt_state = FAULT;
                end else begin
                    nxt_tcnt = tcnt + 16'd1;
                end
            end
            COIN_PULSE: begin
                if (pcnt == 8'(PULSE_W - 1)) begin
                    nxt_state = COIN_WAIT;
                    nxt_tcnt  = 16'd0;
                end else begin
                    nxt_pcnt = pcnt + 8'd1;
                end
            end
            COIN_WAIT: begin
                if (coin_done) begin
                    nxt_coins = coins - 2'd1;
                    if (coins == 2'd1) begin
                        nxt_state = IDLE;
                    end else begin
                        nxt_state = COIN_PULSE;
                        nxt_pcnt  = 8'd0;
                    end
                end else if (tcnt == 16'(TIMEOUT - 1)) begin
                    nxt_state = FAULT;
                end else begin
                    nxt_tcnt = tcnt + 16'd1;
                end
            end
            default: begin
                nxt_state = FAULT;
            end
        endcase

        if (launch) begin
            nxt_coins = l_coins;
            if (l_vend) begin
                nxt_state = ITEM;
                nxt_tcnt  = 16'd0;
            end else begin
                nxt_state = COIN_PULSE;
                nxt_pcnt  = 8'd0;
            end
        end

        // Requests not started directly go to the one-deep queue or are dropped
        if (req && !take_new && state != FAULT && nxt_state != FAULT) begin
            if (!nxt_pvld) begin
                nxt_pvld   = 1'b1;
                nxt_pvend  = vend;
                nxt_pcoins = req_coins;
            end else begin
                nxt_ovf = 1'b1;
            end
        end

        if (nxt_state == FAULT) nxt_pvld = 1'b0;
    end

    // State, counters and Moore outputs registered from the next state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            coins      <= 2'd0;
            pcnt       <= 8'd0;
            tcnt       <= 16'd0;
            pvld       <= 1'b0;
            pvend      <= 1'b0;
            pcoins     <= 2'd0;
            item_motor <= 1'b0;
            coin_eject <= 1'b0;
            busy       <= 1'b0;
            overflow   <= 1'b0;
            fault      <= 1'b0;
        end else begin
            state      <= nxt_state;
            coins      <= nxt_coins;
            pcnt       <= nxt_pcnt;
            tcnt       <= nxt_tcnt;
            pvld       <= nxt_pvld;
            pvend      <= nxt_pvend;
            pcoins     <= nxt_pcoins;
            item_motor <= (nxt_state == ITEM);
            coin_eject <= (nxt_state == COIN_PULSE);
            busy       <= (nxt_state != IDLE) | nxt_pvld;
            overflow   <= nxt_ovf;
            fault      <= (nxt_state == FAULT);
        end
    end

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser with default parameters.
module tb_change_dispenser;

    logic       clk;
    logic       rst;
    logic       vend;
    logic [1:0] change;
    logic       item_done;
    logic       coin_done;
    logic       item_motor;
    logic       coin_eject;
    logic       busy;
    logic       overflow;
    logic       fault;

    int total = 0;
    int bad   = 0;

    change_dispenser #(.PULSE_W(4), .TIMEOUT(1000)) dut (
        .clk        (clk),
        .rst        (rst),
        .vend       (vend),
        .change     (change),
        .item_done  (item_done),
        .coin_done  (coin_done),
        .item_motor (item_motor),
        .coin_eject (coin_eject),
        .busy       (busy),
        .overflow   (overflow),
        .fault      (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; sample point is 1 time unit after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [4:0] exp);
        chk({tag, ".outs"}, {27'd0, item_motor, coin_eject, busy, overflow, fault}, {27'd0, exp});
    endtask

    // Called just after entering COIN_PULSE: 4 cycles high, then low in COIN_WAIT
    task automatic pulse_check(input string tag);
        chk({tag, ".eject0"}, {31'd0, coin_eject}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk({tag, ".eject_hold"}, {31'd0, coin_eject}, 32'd1);
        end
        tick();
        chk({tag, ".eject_end"}, {31'd0, coin_eject}, 32'd0);
        chk({tag, ".busy_wait"}, {31'd0, busy}, 32'd1);
    endtask

    initial begin
        rst = 1'b0; vend = 1'b0; change = 2'b00; item_done = 1'b0; coin_done = 1'b0;
        #7;
        // outs order: {item_motor, coin_eject, busy, overflow, fault}
        chk_all("reset", 5'b00000);
        #5;
        rst = 1'b1;
        tick();
        chk_all("idle", 5'b00000);

        // Bottle only, item_done after 5 cycles of motor
        vend = 1'b1;
        tick();
        vend = 1'b0;
        chk_all("vend.start", 5'b10100);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("vend.motor", {31'd0, item_motor}, 32'd1);
            chk("vend.noeject", {31'd0, coin_eject}, 32'd0);
        end
        item_done = 1'b1;
        tick();
        item_done = 1'b0;
        chk_all("vend.done", 5'b00000);

        // Rs10 change: two pulses, coin_done 3 cycles after each pulse
        change = 2'b10;
        tick();
        change = 2'b00;
        pulse_check("rs10.p1");
        tick(); tick();
        coin_done = 1'b1;
        tick();
        coin_done = 1'b0;
        pulse_check("rs10.p2");
        tick(); tick();
        coin_done = 1'b1;
        tick();
        coin_done = 1'b0;
        chk_all("rs10.done", 5'b00000);

        // Queue and overflow
        vend = 1'b1; change = 2'b01;
        tick();
        change = 2'b00;
        tick();
        vend = 1'b0; change = 2'b01;
        tick();
        change = 2'b00;
        chk_all("q.ovf", 5'b10110);
        item_done = 1'b1;
        tick();
        item_done = 1'b0;
        pulse_check("q.coin");
        coin_done = 1'b1;
        tick();
        coin_done = 1'b0;
        chk_all("q.idle_pending", 5'b00110);
        tick();
        chk_all("q.second", 5'b10110);
        item_done = 1'b1;
        tick();
        item_done = 1'b0;
        chk_all("q.done", 5'b00010);
        rst = 1'b0;
        #2;
        chk_all("q.reset", 5'b00000);
        rst = 1'b1;

        // Reserved change code
        change = 2'b11;
        tick();
        chk_all("c11.none", 5'b00000);
        tick();
        chk_all("c11.none2", 5'b00000);
        vend = 1'b1;
        tick();
        vend = 1'b0; change = 2'b00;
        chk_all("c11.vend", 5'b10100);
        item_done = 1'b1;
        tick();
        item_done = 1'b0;
        chk_all("c11.done", 5'b00000);

        // Stray sensors in IDLE are ignored
        coin_done = 1'b1; item_done = 1'b1;
        tick();
        coin_done = 1'b0; item_done = 1'b0;
        chk_all("stray", 5'b00000);

        // Asynchronous reset during COIN_PULSE, then request right after release
        change = 2'b01;
        tick();
        change = 2'b00;
        chk("rstmid.eject", {31'd0, coin_eject}, 32'd1);
        tick();
        rst = 1'b0;
        #2;
        chk_all("rstmid.async", 5'b00000);
        rst = 1'b1;
        vend = 1'b1;
        tick();
        vend = 1'b0;
        chk_all("rstrel.first", 5'b10100);
        item_done = 1'b1;
        tick();
        item_done = 1'b0;
        chk_all("rstrel.done", 5'b00000);

        // Sensor on the very cycle the timeout is reached counts as success
        vend = 1'b1;
        tick();
        vend = 1'b0;
        repeat (999) tick();
        chk_all("tmo.edge_item", 5'b10100);
        item_done = 1'b1;
        tick();
        item_done = 1'b0;
        chk_all("tmo.edge_ok", 5'b00000);

        // Timeout into FAULT
        vend = 1'b1;
        tick();
        vend = 1'b0;
        repeat (999) tick();
        chk_all("fault.before", 5'b10100);
        tick();
        chk_all("fault.entered", 5'b00101);
        vend = 1'b1; change = 2'b10;
        tick();
        tick();
        vend = 1'b0; change = 2'b00;
        chk_all("fault.ignore", 5'b00101);
        rst = 1'b0;
        #2;
        chk_all("fault.reset", 5'b00000);
        rst = 1'b1;
        tick();
        chk_all("fault.after", 5'b00000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
